// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants; the jump opcodes are also used by the hazard unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;
    localparam int unsigned PC_STEP  = 4;

    localparam logic [6:0] OPC_JAL  = 7'b110_1111;
    localparam logic [6:0] OPC_JALR = 7'b110_0111;

    function automatic logic is_jump(input logic [6:0] opcode);
        return (opcode == OPC_JAL) || (opcode == OPC_JALR);
    endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry {pc, insn} buffer that parks a response while IF/ID is not accepting.
module fetch_hold_buf
    import fetch_pkg::*;
#(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [AWIDTH-1:0] load_pc,
    input  logic [DWIDTH-1:0] load_insn,
    output logic              valid,
    output logic [AWIDTH-1:0] pc,
    output logic [DWIDTH-1:0] insn
);

    // clear wins so a redirect can never leave a wrong-path instruction parked
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            pc    <= '0;
            insn  <= DWIDTH'(NOP_INSN);
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= load_pc;
            insn  <= load_insn;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: PC register, single-outstanding imem request FSM, redirect handling and IF/ID register.
//
// state | meaning
// REQ   | ready to issue a request at f_pc (suppressed by stall_if)
// WAIT  | request accepted, response pending on the correct path
// HOLD  | response parked in the hold buffer until IF/ID accepts it
// DRAIN | request pending on a wrong path; its response is discarded
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                AWIDTH   = 32,
    parameter int                DWIDTH   = 32,
    parameter logic [AWIDTH-1:0] BASEADDR = 32'h0100_0000,
    parameter logic [DWIDTH-1:0] NOP      = NOP_INSN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_if,
    input  logic              ifid_wren,
    input  logic              ifid_flush,
    input  logic              redirect_valid,
    input  logic [AWIDTH-1:0] redirect_pc,
    output logic              imem_req_valid,
    output logic [AWIDTH-1:0] imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_rsp_valid,
    input  logic [DWIDTH-1:0] imem_rsp_data,
    output logic [AWIDTH-1:0] f_pc,
    output logic [AWIDTH-1:0] d_pc,
    output logic [DWIDTH-1:0] d_insn,
    output logic              d_valid
);

    fetch_state_e      state, state_n;
    logic [AWIDTH-1:0] pc_n;
    logic              req_valid;
    logic              req_fire;
    logic              buf_load, buf_clear;
    logic              buf_valid;
    logic [AWIDTH-1:0] buf_pc;
    logic [DWIDTH-1:0] buf_insn;
    logic              insn_avail;
    logic [AWIDTH-1:0] avail_pc;
    logic [DWIDTH-1:0] avail_insn;

    fetch_hold_buf #(
        .AWIDTH (AWIDTH),
        .DWIDTH (DWIDTH)
    ) u_hold_buf (
        .clk       (clk),
        .reset     (reset),
        .load      (buf_load),
        .clear     (buf_clear),
        .load_pc   (f_pc),
        .load_insn (imem_rsp_data),
        .valid     (buf_valid),
        .pc        (buf_pc),
        .insn      (buf_insn)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= REQ;
            f_pc  <= BASEADDR;
        end else begin
            state <= state_n;
            f_pc  <= pc_n;
        end
    end

    always_comb begin
        state_n   = state;
        pc_n      = f_pc;
        req_valid = 1'b0;
        req_fire  = 1'b0;
        buf_load  = 1'b0;
        buf_clear = 1'b0;
        case (state)
            REQ: begin
                req_valid = ~stall_if;
                req_fire  = req_valid & imem_req_ready;
                if (req_fire) state_n = WAIT;
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    pc_n = f_pc + AWIDTH'(PC_STEP);
                    if (ifid_wren) begin
                        state_n = REQ;
                    end else begin
                        buf_load = 1'b1;
                        state_n  = HOLD;
                    end
                end
            end
            HOLD: begin
                if (ifid_wren) begin
                    buf_clear = 1'b1;
                    state_n   = REQ;
                end
            end
            DRAIN: begin
                if (imem_rsp_valid) state_n = REQ;
            end
            default: state_n = REQ;
        endcase

        // a redirect wins over everything; stay in DRAIN while a request is still in flight
        if (redirect_valid) begin
            pc_n      = redirect_pc;
            buf_load  = 1'b0;
            buf_clear = 1'b1;
            if (((state == WAIT || state == DRAIN) && !imem_rsp_valid) || req_fire)
                state_n = DRAIN;
            else
                state_n = REQ;
        end
    end

    assign imem_req_valid = req_valid & ~reset;
    assign imem_req_addr  = f_pc;

    assign insn_avail = ~redirect_valid &
                        (((state == WAIT) & imem_rsp_valid) | ((state == HOLD) & buf_valid));
    assign avail_pc   = (state == HOLD) ? buf_pc   : f_pc;
    assign avail_insn = (state == HOLD) ? buf_insn : imem_rsp_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_pc    <= BASEADDR;
            d_insn  <= NOP;
            d_valid <= 1'b0;
        end else if (ifid_flush) begin
            d_insn  <= NOP;
            d_valid <= 1'b0;
        end else if (ifid_wren) begin
            if (insn_avail) begin
                d_pc    <= avail_pc;
                d_insn  <= avail_insn;
                d_valid <= 1'b1;
            end else begin
                d_insn  <= NOP;
                d_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed tables/sequences plus random traffic against a transaction model.
module tb_fetch_unit;

    localparam logic [31:0] BASE = 32'h0100_0000;
    localparam logic [31:0] NOPI = 32'h0000_0013;

    logic        clk, reset;
    logic        stall_if, ifid_wren, ifid_flush, redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [31:0] imem_req_addr, imem_rsp_data;
    logic [31:0] f_pc, d_pc, d_insn;
    logic        d_valid;

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .stall_if       (stall_if),
        .ifid_wren      (ifid_wren),
        .ifid_flush     (ifid_flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .f_pc           (f_pc),
        .d_pc           (d_pc),
        .d_insn         (d_insn),
        .d_valid        (d_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_0013;
    endfunction

    // imem model: one pending slot, response lat cycles after the accepting edge
    int unsigned ready_pct;
    int unsigned lat_min, lat_max;
    bit          mem_pend;
    logic [31:0] mem_addr;
    int          mem_cnt;

    // reference model in terms of outstanding/stale/held transactions
    logic [31:0] m_pc, m_dpc, m_dinsn, m_held_pc, m_held_insn;
    bit          m_out, m_stale, m_held, m_dvalid;

    bit          s_rv, s_dv;
    logic [31:0] s_addr, s_dpc, s_dinsn, s_fpc;
    bit          seq_on, arm_first;
    logic [31:0] seq_last, first_fire_addr;

    task automatic model_reset();
        m_pc = BASE; m_dpc = BASE; m_dinsn = NOPI; m_dvalid = 0;
        m_out = 0; m_stale = 0; m_held = 0;
        mem_pend = 0;
    endtask

    task automatic model_update(input bit st, input bit wr, input bit fl, input bit rd,
                                input logic [31:0] rp, input bit fire, input bit rsp,
                                input logic [31:0] data);
        bit got, good;
        got  = rsp && m_out;
        good = got && !m_stale && !rd;
        if (fl) begin
            m_dinsn = NOPI; m_dvalid = 0;
        end else if (wr) begin
            if (good) begin
                m_dpc = m_pc; m_dinsn = data; m_dvalid = 1;
            end else if (m_held && !rd) begin
                m_dpc = m_held_pc; m_dinsn = m_held_insn; m_dvalid = 1;
            end else begin
                m_dinsn = NOPI; m_dvalid = 0;
            end
        end
        if (rd) begin
            m_pc    = rp;
            m_held  = 0;
            m_out   = (m_out && !got) || fire;
            m_stale = m_out;
        end else begin
            if (got) begin
                m_out = 0;
                if (!m_stale) begin
                    if (!wr) begin
                        m_held = 1; m_held_pc = m_pc; m_held_insn = data;
                    end
                    m_pc = m_pc + 32'd4;
                end
            end else if (m_held && wr) begin
                m_held = 0;
            end
            if (fire) begin
                m_out = 1; m_stale = 0;
            end
        end
        if (st && fire) m_out = m_out; // stall never coexists with a model fire
    endtask

    // one clock: drive at negedge, sample #1 later, advance models at posedge, return at negedge
    task automatic step(input bit st, input bit wr, input bit fl, input bit rd, input logic [31:0] rp);
        bit          exp_rv, fire_dut, fire_m, rsp;
        logic [31:0] acc_addr, data;
        stall_if       = st;
        ifid_wren      = wr;
        ifid_flush     = fl;
        redirect_valid = rd;
        redirect_pc    = rp;
        imem_req_ready = ($urandom_range(99) < ready_pct);
        imem_rsp_valid = mem_pend && (mem_cnt == 0);
        imem_rsp_data  = imem_rsp_valid ? mem_word(mem_addr) : 32'hDEAD_BEEF;
        #1;
        exp_rv = !m_out && !m_held && !st;
        check1("req_valid", imem_req_valid, exp_rv);
        check("req_addr", imem_req_addr, m_pc);
        check("f_pc", f_pc, m_pc);
        check("d_pc", d_pc, m_dpc);
        check("d_insn", d_insn, m_dinsn);
        check1("d_valid", d_valid, m_dvalid);
        s_rv = imem_req_valid; s_addr = imem_req_addr; s_dv = d_valid;
        s_dpc = d_pc; s_dinsn = d_insn; s_fpc = f_pc;
        fire_dut = imem_req_valid && imem_req_ready;
        fire_m   = exp_rv && imem_req_ready;
        acc_addr = imem_req_addr;
        rsp      = imem_rsp_valid;
        data     = imem_rsp_data;
        @(posedge clk);
        model_update(st, wr, fl, rd, rp, fire_m, rsp, data);
        if (rsp) mem_pend = 0;
        else if (mem_pend) mem_cnt--;
        if (fire_dut) begin
            check1("one_outstanding", mem_pend, 1'b0);
            if (seq_on) check("req_seq", acc_addr, seq_last + 32'd4);
            if (arm_first) begin
                first_fire_addr = acc_addr;
                arm_first = 0;
            end
            seq_last = acc_addr;
            mem_pend = 1;
            mem_addr = acc_addr;
            mem_cnt  = int'($urandom_range(lat_max, lat_min)) - 1;
        end
        @(negedge clk);
    endtask

    // asynchronous reset asserted mid-cycle; outputs must drop before any clock edge
    task automatic do_reset();
        #2;
        reset = 1'b1;
        stall_if = 0; ifid_wren = 0; ifid_flush = 0; redirect_valid = 0;
        imem_req_ready = 0; imem_rsp_valid = 0;
        #1;
        check("rst_f_pc", f_pc, BASE);
        check("rst_d_pc", d_pc, BASE);
        check("rst_d_insn", d_insn, NOPI);
        check1("rst_d_valid", d_valid, 1'b0);
        check1("rst_req_valid", imem_req_valid, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        reset = 1'b0;
    endtask

    function automatic bit rsp_due();
        return mem_pend && (mem_cnt == 0);
    endfunction

    typedef struct {
        bit          st, wr;
        bit          e_rv, e_dv;
        logic [31:0] e_addr, e_dpc;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int n, prev;
        bit found;
        // startup, then a 3-cycle stall/no-write window around the response for BASE+8
        tbl[0]  = '{0, 1, 1, 0, BASE + 32'h0, BASE + 32'h0};
        tbl[1]  = '{0, 1, 0, 0, BASE + 32'h0, BASE + 32'h0};
        tbl[2]  = '{0, 1, 1, 1, BASE + 32'h4, BASE + 32'h0};
        tbl[3]  = '{0, 1, 0, 0, BASE + 32'h4, BASE + 32'h0};
        tbl[4]  = '{0, 1, 1, 1, BASE + 32'h8, BASE + 32'h4};
        tbl[5]  = '{1, 0, 0, 0, BASE + 32'h8, BASE + 32'h4};
        tbl[6]  = '{1, 0, 0, 0, BASE + 32'hC, BASE + 32'h4};
        tbl[7]  = '{1, 0, 0, 0, BASE + 32'hC, BASE + 32'h4};
        tbl[8]  = '{0, 1, 0, 0, BASE + 32'hC, BASE + 32'h4};
        tbl[9]  = '{0, 1, 1, 1, BASE + 32'hC, BASE + 32'h8};
        tbl[10] = '{0, 1, 0, 0, BASE + 32'hC, BASE + 32'h8};

        reset = 1'b1;
        stall_if = 0; ifid_wren = 0; ifid_flush = 0; redirect_valid = 0; redirect_pc = '0;
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0;
        seq_on = 0; arm_first = 0; seq_last = '0; first_fire_addr = '0;
        ready_pct = 100; lat_min = 1; lat_max = 1;
        model_reset();
        @(negedge clk);
        do_reset();

        for (int i = 0; i < 11; i++) begin
            step(tbl[i].st, tbl[i].wr, 1'b0, 1'b0, 32'h0);
            check1($sformatf("tbl%0d_rv", i), s_rv, tbl[i].e_rv);
            check($sformatf("tbl%0d_addr", i), s_addr, tbl[i].e_addr);
            check1($sformatf("tbl%0d_dv", i), s_dv, tbl[i].e_dv);
            check($sformatf("tbl%0d_dpc", i), s_dpc, tbl[i].e_dpc);
            if (i == 9) check("hold_insn", s_dinsn, mem_word(BASE + 32'h8));
        end

        // 3-cycle response: one request at a time, consecutive addresses, evenly spaced d_valid
        lat_min = 3; lat_max = 3; seq_on = 1; prev = -1;
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 0, 0, 32'h0);
            if (s_dv) begin
                if (prev >= 0) check("dv_gap", 32'(i - prev), 32'd4);
                prev = i;
            end
        end
        seq_on = 0;

        // redirect while a request is outstanding: late response must be dropped
        n = 0;
        while (!(mem_pend && mem_cnt > 0) && n < 10) begin step(0, 1, 0, 0, 32'h0); n++; end
        check1("t4_reach_wait", mem_pend && mem_cnt > 0, 1'b1);
        step(0, 1, 1, 1, BASE + 32'h100);
        arm_first = 1; found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(0, 1, 0, 0, 32'h0);
            found = s_dv;
        end
        check1("t4_dv_seen", found, 1'b1);
        check("t4_d_pc", s_dpc, BASE + 32'h100);
        check1("t4_req_seen", arm_first, 1'b0);
        check("t4_first_req", first_fire_addr, BASE + 32'h100);
        arm_first = 0;

        // redirect + flush in the same cycle as a good response
        lat_min = 1; lat_max = 1;
        n = 0;
        while (!rsp_due() && n < 10) begin step(0, 1, 0, 0, 32'h0); n++; end
        check1("t5_rsp_due", rsp_due(), 1'b1);
        step(0, 1, 1, 1, BASE + 32'h200);
        step(0, 1, 0, 0, 32'h0);
        check1("t5_d_valid", s_dv, 1'b0);
        check1("t5_req_valid", s_rv, 1'b1);
        check("t5_req_addr", s_addr, BASE + 32'h200);

        // reset while waiting at the top of the address space
        lat_min = 3; lat_max = 3;
        step(0, 1, 1, 1, 32'hFFFF_FFFC);
        n = 0;
        while (!(mem_pend && mem_cnt > 0) && n < 10) begin step(0, 1, 0, 0, 32'h0); n++; end
        check1("t6_reach_wait", mem_pend && mem_cnt > 0, 1'b1);
        check("t6_pc_before", f_pc, 32'hFFFF_FFFC);
        do_reset();
        step(0, 1, 0, 0, 32'h0);
        check1("t6_post_rst_rv", s_rv, 1'b1);
        check("t6_post_rst_addr", s_addr, BASE);

        // PC wrap from 0xFFFF_FFFC to 0
        lat_min = 1; lat_max = 1;
        step(0, 1, 1, 1, 32'hFFFF_FFFC);
        found = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            step(0, 1, 0, 0, 32'h0);
            found = s_dv;
        end
        check1("t6_dv_seen", found, 1'b1);
        check("t6_wrap_dpc", s_dpc, 32'hFFFF_FFFC);
        check("t6_wrap_fpc", s_fpc, 32'h0000_0000);
        step(0, 1, 0, 0, 32'h0);
        check("t6_wrap_req", s_addr, 32'h0000_0000);

        // random traffic against the model
        ready_pct = 70; lat_min = 1; lat_max = 4;
        for (int i = 0; i < 500; i++) begin
            bit st, wr, fl, rd;
            logic [31:0] rp;
            st = ($urandom_range(99) < 25);
            wr = ($urandom_range(99) < 75);
            fl = ($urandom_range(99) < 10);
            rd = ($urandom_range(99) < 8);
            rp = BASE + ($urandom_range(255) << 2);
            step(st, wr, fl, rd, rp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
